hub75_scan_controller: RTL and testbench

Sequencer for the HUB75 LED matrix output path. It reads bit-planes from a planar framebuffer over a one-cycle-latency read port, shifts one row-pair of pixels into the panel, then latches and displays each plane with binary-coded-modulation (BCM) on-times. It drives every panel pin (`o_clk`, `o_latch`, `o_blank`, `o_data_r/g/b`, `o_row_select`) and replaces the current divider/accumulator/comparator cluster with a single scheduled FSM.

---
 rtl/hub75_scan_controller_pkg.sv | 37 +++
 rtl/hub75_scan_controller_if.sv | 24 ++
 rtl/hub75_scan_controller_display_timer.sv | 27 ++
 rtl/hub75_scan_controller.sv | 205 ++++++++++++++++++++
 tb/tb_hub75_scan_controller.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_scan_controller_pkg.sv
// Shared types and constants for the HUB75 scan controller: FSM state encoding,
// row-address width and the field layout of a planar framebuffer word.
package display_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        BLANK,
        LATCH,
        DISPLAY,
        NEXT
    } scan_state_t;

    localparam int ROW_W = 5;

    // Pixel word is {b[1:0], g[1:0], r[1:0]}; bit 0 of each field is the upper half-panel.
    localparam int PIX_W     = 6;
    localparam int CH_W      = 2;
    localparam int PIX_R_LSB = 0;
    localparam int PIX_G_LSB = 2;
    localparam int PIX_B_LSB = 4;

    function automatic int chan_lsb(input int ch);
        case (ch)
            0:       return PIX_R_LSB;
            1:       return PIX_G_LSB;
            default: return PIX_B_LSB;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hub75_scan_controller_if.sv
// Framebuffer read port: strobe and {row, plane, col} address out, planar pixel
// word back exactly one cycle after the strobe.
interface hub75_scan_controller_if #(
    parameter int ADDR_W = 13
);
    import display_pkg::*;

    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [PIX_W-1:0]  i_rd_data;

    modport master (
        output o_rd_en,
        output o_rd_addr,
        input  i_rd_data
    );

    modport slave (
        input  o_rd_en,
        input  o_rd_addr,
        output i_rd_data
    );

endinterface

// File: rtl/hub75_scan_controller_display_timer.sv
// Loadable down-counter shared by the shift half-periods and the BCM display time.
// done is high while the count sits at zero.
module display_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/hub75_scan_controller.sv
// HUB75 scan sequencer: fetch each pixel of a row-pair for one bit-plane, shift it
// into the panel, latch it and display it for a binary-weighted number of cycles.
module hub75_scan_controller
    import display_pkg::*;
#(
    parameter int COLS       = 64,
    parameter int BITS       = 4,
    parameter int CLK_DIV    = 2,
    parameter int BLANK_BASE = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_enable,
    hub75_scan_controller_if.master     fb,
    output logic                        o_clk,
    output logic                        o_latch,
    output logic                        o_blank,
    output logic [CH_W-1:0]             o_data_r,
    output logic [CH_W-1:0]             o_data_g,
    output logic [CH_W-1:0]             o_data_b,
    output logic [ROW_W-1:0]            o_row_select,
    output logic                        o_frame_done,
    output logic                        o_busy
);

    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PLANE_W  = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int DISP_MAX = BLANK_BASE << (BITS - 1);
    localparam int TMR_W    = $clog2(max_int(DISP_MAX, CLK_DIV) + 1);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BITS - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = {ROW_W{1'b1}};

    scan_state_t        state_reg, state_next;
    logic [COL_W-1:0]   col_reg, col_next;
    logic [PLANE_W-1:0] plane_reg, plane_next;
    logic [ROW_W-1:0]   row_reg, row_next;

    logic               timer_load;
    logic [TMR_W-1:0]   timer_value;
    logic               timer_done;
    logic [TMR_W-1:0]   display_len;
    logic               frame_wrap;

    logic               rd_en_reg;
    logic               fetch_d_reg;
    logic               sclk_reg;
    logic               latch_reg;
    logic               blank_reg;
    logic [ROW_W-1:0]   row_sel_reg;
    logic               frame_done_reg;
    logic               busy_reg;

    assign display_len = (TMR_W'(BLANK_BASE) << plane_reg) - TMR_W'(1);

    display_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_comb begin
        state_next  = state_reg;
        col_next    = col_reg;
        plane_next  = plane_reg;
        row_next    = row_reg;
        timer_load  = 1'b0;
        timer_value = TMR_W'(CLK_DIV - 1);
        frame_wrap  = 1'b0;
        case (state_reg)
            IDLE: begin
                col_next   = '0;
                plane_next = '0;
                row_next   = '0;
                if (i_enable) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                timer_load = 1'b1;
                state_next = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (timer_done) begin
                    if (col_reg == COL_LAST) begin
                        col_next   = '0;
                        state_next = BLANK;
                    end else begin
                        col_next   = col_reg + COL_W'(1);
                        state_next = FETCH;
                    end
                end
            end
            BLANK: begin
                state_next = LATCH;
            end
            LATCH: begin
                timer_load  = 1'b1;
                timer_value = display_len;
                state_next  = DISPLAY;
            end
            DISPLAY: begin
                if (timer_done) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (plane_reg == PLANE_LAST) begin
                    plane_next = '0;
                    row_next   = row_reg + ROW_W'(1);
                    frame_wrap = (row_reg == ROW_LAST);
                end else begin
                    plane_next = plane_reg + PLANE_W'(1);
                end
                state_next = i_enable ? FETCH : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            plane_reg <= '0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            plane_reg <= plane_next;
            row_reg   <= row_next;
        end
    end

    // Panel pins are registered from the current state, so they trail the internal
    // FSM by one cycle; this gives read data a full cycle to land before o_clk rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_en_reg      <= 1'b0;
            fetch_d_reg    <= 1'b0;
            sclk_reg       <= 1'b0;
            latch_reg      <= 1'b0;
            blank_reg      <= 1'b1;
            row_sel_reg    <= '0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            rd_en_reg      <= (state_next == FETCH);
            fetch_d_reg    <= (state_reg == FETCH);
            sclk_reg       <= (state_reg == SHIFT_HI);
            latch_reg      <= (state_reg == LATCH);
            blank_reg      <= (state_reg != DISPLAY);
            frame_done_reg <= frame_wrap;
            busy_reg       <= (state_reg != IDLE);
            if (state_reg == BLANK) begin
                row_sel_reg <= row_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [CH_W-1:0] chan_reg;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    chan_reg <= '0;
                end else if (fetch_d_reg) begin
                    chan_reg <= fb.i_rd_data[chan_lsb(gi) +: CH_W];
                end
            end
        end

        if (BITS > 1) begin : g_addr_planes
            assign fb.o_rd_addr = {row_reg, plane_reg, col_reg};
        end else begin : g_addr_flat
            assign fb.o_rd_addr = {row_reg, col_reg};
        end
    endgenerate

    assign fb.o_rd_en   = rd_en_reg;
    assign o_data_r     = g_chan[0].chan_reg;
    assign o_data_g     = g_chan[1].chan_reg;
    assign o_data_b     = g_chan[2].chan_reg;
    assign o_clk        = sclk_reg;
    assign o_latch      = latch_reg;
    assign o_blank      = blank_reg;
    assign o_row_select = row_sel_reg;
    assign o_frame_done = frame_done_reg;
    assign o_busy       = busy_reg;

endmodule

// File: tb/tb_hub75_scan_controller.sv
// Directed bench for hub75_scan_controller with COLS=4, BITS=2, CLK_DIV=1, BLANK_BASE=4;
// a registered-read framebuffer model returns col*9+plane.
module tb_hub75_scan_controller;

    localparam int COLS       = 4;
    localparam int BITS       = 2;
    localparam int CLK_DIV    = 1;
    localparam int BLANK_BASE = 4;
    localparam int ADDR_W     = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       o_clk, o_latch, o_blank, frame_done, busy;
    logic [1:0] dr, dg, db;
    logic [4:0] row_sel;

    int errors = 0;
    int checks = 0;

    hub75_scan_controller_if #(.ADDR_W(ADDR_W)) fb();

    hub75_scan_controller #(
        .COLS       (COLS),
        .BITS       (BITS),
        .CLK_DIV    (CLK_DIV),
        .BLANK_BASE (BLANK_BASE)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .fb           (fb),
        .o_clk        (o_clk),
        .o_latch      (o_latch),
        .o_blank      (o_blank),
        .o_data_r     (dr),
        .o_data_g     (dg),
        .o_data_b     (db),
        .o_row_select (row_sel),
        .o_frame_done (frame_done),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fb.o_rd_en) begin
            fb.i_rd_data <= 6'(int'(fb.o_rd_addr[1:0]) * 9 + int'(fb.o_rd_addr[2]));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observe one row-plane, starting on its column-0 fetch and ending on the next one.
    task automatic run_rp(output int n, output int rises, output logic [23:0] words,
                          output int latch_n, output int blank_low, output int rs_at_latch,
                          output int fd_n, output logic fd_last, output logic [7:0] end_addr);
        logic prev_clk;
        n = 0; rises = 0; words = '0; latch_n = 0; blank_low = 0;
        rs_at_latch = -1; fd_n = 0; fd_last = 1'b0;
        prev_clk = o_clk;
        do begin
            step();
            n++;
            if (o_clk && !prev_clk) begin
                if (rises < 4) words[rises*6 +: 6] = {db, dg, dr};
                rises++;
            end
            prev_clk = o_clk;
            if (o_latch) begin
                latch_n++;
                rs_at_latch = int'(row_sel);
            end
            if (!o_blank) blank_low++;
            fd_last = frame_done;
            if (frame_done) fd_n++;
        end while (!(fb.o_rd_en && fb.o_rd_addr[1:0] == 2'd0) && n < 100);
        end_addr = fb.o_rd_addr;
    endtask

    initial begin
        int n, rises, latch_n, blank_low, rs, fd_n, fd_total, bad, fetches, exp_n;
        logic [23:0] words;
        logic fd_last;
        logic [7:0] end_addr, exp_addr;

        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();

        // 1: idle after reset
        check("idle_blank", o_blank, 1);
        check("idle_busy", busy, 0);
        check("idle_clk", o_clk, 0);
        check("idle_latch", o_latch, 0);
        check("idle_data", {db, dg, dr}, 0);
        check("idle_row_sel", row_sel, 0);
        check("idle_frame_done", frame_done, 0);
        check("idle_rd_en", fb.o_rd_en, 0);
        check("idle_rd_addr", fb.o_rd_addr, 0);

        // 2: row 0 plane 0
        enable = 1'b1;
        step();
        check("first_rd_en", fb.o_rd_en, 1);
        check("first_rd_addr", fb.o_rd_addr, 0);
        run_rp(n, rises, words, latch_n, blank_low, rs, fd_n, fd_last, end_addr);
        check("p0_cycles", n, 19);
        check("p0_clk_rises", rises, 4);
        check("p0_data", words, {6'd27, 6'd18, 6'd9, 6'd0});
        check("p0_latch_cycles", latch_n, 1);
        check("p0_blank_low", blank_low, 4);
        check("p0_frame_done", fd_n, 0);
        check("p0_next_addr", end_addr, 8'd4);

        // 3: row 0 plane 1, then row select on row 1
        run_rp(n, rises, words, latch_n, blank_low, rs, fd_n, fd_last, end_addr);
        check("p1_cycles", n, 23);
        check("p1_data", words, {6'd28, 6'd19, 6'd10, 6'd1});
        check("p1_blank_low", blank_low, 8);
        check("p1_latch_cycles", latch_n, 1);
        check("p1_row_sel", rs, 0);
        check("p1_next_addr", end_addr, 8'd8);
        check("p1_frame_done", fd_n, 0);
        run_rp(n, rises, words, latch_n, blank_low, rs, fd_n, fd_last, end_addr);
        check("r1p0_row_sel", rs, 1);
        check("r1p0_cycles", n, 19);

        // 4: rest of the frame
        fd_total = fd_n;
        bad = 0;
        for (int rp = 3; rp < 64; rp++) begin
            run_rp(n, rises, words, latch_n, blank_low, rs, fd_n, fd_last, end_addr);
            fd_total += fd_n;
            exp_n = (rp % 2 == 1) ? 23 : 19;
            exp_addr = {5'((rp + 1) / 2), 1'((rp + 1) % 2), 2'b00};
            if (n != exp_n || end_addr != exp_addr || rs != rp / 2 || latch_n != 1) bad++;
        end
        check("frame_rowplane_errors", bad, 0);
        check("frame_done_count", fd_total, 1);
        check("frame_done_in_last_next", fd_last, 1);
        check("wrap_rd_addr", end_addr, 0);
        check("wrap_rd_en", fb.o_rd_en, 1);

        // 5: drop enable during column 2 of row 0 plane 1
        run_rp(n, rises, words, latch_n, blank_low, rs, fd_n, fd_last, end_addr);
        n = 0;
        while (!(fb.o_rd_en && fb.o_rd_addr[1:0] == 2'd2) && n < 20) begin
            step();
            n++;
        end
        check("reach_col2_addr", fb.o_rd_addr, 8'd6);
        enable = 1'b0;
        n = 0; latch_n = 0; blank_low = 0; fetches = 0;
        do begin
            step();
            n++;
            if (o_latch) latch_n++;
            if (!o_blank) blank_low++;
            if (fb.o_rd_en) fetches++;
        end while (busy && n < 60);
        check("drop_busy", busy, 0);
        check("drop_latch_cycles", latch_n, 1);
        check("drop_blank_low", blank_low, 8);
        check("drop_fetches", fetches, 1);
        check("drop_addr_cleared", fb.o_rd_addr, 0);
        repeat (3) step();
        check("drop_idle_rd_en", fb.o_rd_en, 0);
        check("drop_idle_blank", o_blank, 1);
        enable = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!fb.o_rd_en && n < 10);
        check("reenable_rd_en", fb.o_rd_en, 1);
        check("reenable_addr", fb.o_rd_addr, 0);

        // 6: asynchronous reset during display of row 2
        for (int k = 0; k < 4; k++) begin
            run_rp(n, rises, words, latch_n, blank_low, rs, fd_n, fd_last, end_addr);
        end
        check("pre_reset_addr", end_addr, 8'd16);
        n = 0;
        do begin
            step();
            n++;
        end while (o_blank && n < 40);
        check("pre_reset_blank", o_blank, 0);
        check("pre_reset_row_sel", row_sel, 2);
        #3 rst_n = 1'b0;
        #1;
        check("async_blank", o_blank, 1);
        check("async_busy", busy, 0);
        check("async_row_sel", row_sel, 0);
        check("async_rd_addr", fb.o_rd_addr, 0);
        check("async_data", {db, dg, dr}, 0);
        enable = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check("post_reset_addr", fb.o_rd_addr, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_blank", o_blank, 1);
        check("post_reset_rd_en", fb.o_rd_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
